calc: RTL and testbench



---
 rtl/calc_pkg.sv | 35 +++
 rtl/calc_shifter.sv | 53 +++++
 rtl/calc.sv | 103 ++++++++++
 tb/tb_calc.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared decode constants and types for the SIMPLE-style ALU.
// Imported by the ALU top and its barrel shifter.
package calc_pkg;

    localparam logic [1:0] OP1_ALU = 2'b11;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_IN  = 4'b1100;
    localparam logic [3:0] OP_OUT = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Encoding matches op3[1:0] of the shift opcodes, so decode is a direct cast.
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SLR = 2'b01,
        SH_SRL = 2'b10,
        SH_SRA = 2'b11
    } shift_t;

endpackage

// File: rtl/calc_shifter.sv
// Combinational barrel shifter/rotator returning the last bit shifted out.
// Shifts run on a double-width vector so the carry falls out of the extension half.
module calc_shifter
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic [3:0]       amount,
    input  shift_t           kind,
    output logic [WIDTH-1:0] shifted,
    output logic             carry
);

    logic [2*WIDTH-1:0] sll_ext;
    logic [2*WIDTH-1:0] srl_ext;
    logic [2*WIDTH-1:0] sra_ext;
    logic [2*WIDTH-1:0] rot_ext;

    // With amount = 0 the extension bit that supplies the carry is always zero.
    assign sll_ext = {{WIDTH{1'b0}}, value} << amount;
    assign srl_ext = {value, {WIDTH{1'b0}}} >> amount;
    assign sra_ext = $signed({value, {WIDTH{1'b0}}}) >>> amount;
    assign rot_ext = {value, value} << amount;

    always_comb begin
        shifted = '0;
        carry   = 1'b0;
        case (kind)
            SH_SLL: begin
                shifted = sll_ext[WIDTH-1:0];
                carry   = sll_ext[WIDTH];
            end
            SH_SLR: begin
                shifted = rot_ext[2*WIDTH-1:WIDTH];
                carry   = (amount != 4'd0) && rot_ext[WIDTH];
            end
            SH_SRL: begin
                shifted = srl_ext[2*WIDTH-1:WIDTH];
                carry   = srl_ext[WIDTH-1];
            end
            SH_SRA: begin
                shifted = sra_ext[2*WIDTH-1:WIDTH];
                carry   = sra_ext[WIDTH-1];
            end
            default: begin
                shifted = '0;
                carry   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/calc.sv
// SIMPLE-style ALU: decodes op3 of an op1=11 instruction, registers result and {S,Z,C,V}.
// Operand b is Rd, a is Rs; one clock of latency, async active-high reset.
module calc
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       code
);

    logic [1:0]       op1;
    logic [3:0]       op3;
    logic [3:0]       amount;
    logic [5:0]       unused_regs;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sh_value;
    logic             sh_carry;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] flag_src;
    logic             c_next;
    logic             v_next;
    logic             valid;
    logic [3:0]       code_next;

    assign op1         = instr[15:14];
    assign op3         = instr[7:4];
    assign amount      = instr[3:0];
    assign unused_regs = instr[13:8];

    // diff[WIDTH] is the borrow: the widened subtraction wraps iff b < a.
    assign sum  = {1'b0, b} + {1'b0, a};
    assign diff = {1'b0, b} - {1'b0, a};

    calc_shifter #(.WIDTH(WIDTH)) u_shifter (
        .value   (b),
        .amount  (amount),
        .kind    (shift_t'(op3[1:0])),
        .shifted (sh_value),
        .carry   (sh_carry)
    );

    always_comb begin
        res_next = '0;
        flag_src = '0;
        c_next   = 1'b0;
        v_next   = 1'b0;
        valid    = 1'b0;
        if (op1 == OP1_ALU) begin
            valid = 1'b1;
            case (op3)
                OP_ADD: begin
                    res_next = sum[WIDTH-1:0];
                    c_next   = sum[WIDTH];
                    v_next   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB, OP_CMP: begin
                    res_next = (op3 == OP_CMP) ? b : diff[WIDTH-1:0];
                    c_next   = diff[WIDTH];
                    v_next   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != b[WIDTH-1]);
                end
                OP_AND: res_next = b & a;
                OP_OR:  res_next = b | a;
                OP_XOR: res_next = b ^ a;
                OP_MOV: res_next = a;
                OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
                    res_next = sh_value;
                    c_next   = sh_carry;
                end
                default: valid = 1'b0;
            endcase
        end
        // CMP keeps b as the result but reports S/Z of the difference.
        flag_src = (op3 == OP_CMP) ? diff[WIDTH-1:0] : res_next;
    end

    always_comb begin
        code_next = 4'b0000;
        if (valid) begin
            code_next[FLAG_S] = flag_src[WIDTH-1];
            code_next[FLAG_Z] = (flag_src == '0);
            code_next[FLAG_C] = c_next;
            code_next[FLAG_V] = v_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            code   <= 4'b0000;
        end else begin
            result <= res_next;
            code   <= code_next;
        end
    end

endmodule

// File: tb/tb_calc.sv
// Self-checking bench for calc: directed vectors from the test plan plus random
// vectors checked against an arithmetic reference model.
module tb_calc;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic [3:0]  code;

    int vectors;
    int miscompares;

    calc dut (
        .clk    (clk),
        .rst    (rst),
        .instr  (instr),
        .a      (a),
        .b      (b),
        .result (result),
        .code   (code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {S,Z,C,V,result} computed from the opcode rules with plain ints.
    function automatic logic [19:0] ref_alu(input logic [15:0] ins, input logic [15:0] ra,
                                            input logic [15:0] rb);
        int unsigned ua;
        int unsigned ub;
        int          sa;
        int          sb;
        int          st;
        int unsigned t;
        logic [15:0] r;
        logic [15:0] fl;
        logic        c;
        logic        v;
        int          d;
        ua = ra;
        ub = rb;
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        c  = 1'b0;
        v  = 1'b0;
        d  = int'(ins[3:0]);
        if (ins[15:14] != 2'b11) return 20'h0;
        case (ins[7:4])
            4'h0: begin
                t  = ub + ua;
                r  = t[15:0];
                c  = (t > 32'd65535);
                st = sb + sa;
                v  = (st > 32767) || (st < -32768);
                fl = r;
            end
            4'h1, 4'h5: begin
                t  = ub - ua;
                fl = t[15:0];
                c  = (ub < ua);
                st = sb - sa;
                v  = (st > 32767) || (st < -32768);
                r  = (ins[7:4] == 4'h5) ? rb : fl;
            end
            4'h2: begin r = rb & ra; fl = r; end
            4'h3: begin r = rb | ra; fl = r; end
            4'h4: begin r = rb ^ ra; fl = r; end
            4'h6: begin r = ra; fl = r; end
            4'h8, 4'h9, 4'hA, 4'hB: begin
                r = rb;
                for (int k = 0; k < d; k++) begin
                    case (ins[5:4])
                        2'b00: begin c = r[15]; r = {r[14:0], 1'b0}; end
                        2'b01: begin c = r[15]; r = {r[14:0], r[15]}; end
                        2'b10: begin c = r[0]; r = {1'b0, r[15:1]}; end
                        default: begin c = r[0]; r = {r[15], r[15:1]}; end
                    endcase
                end
                fl = r;
            end
            default: return 20'h0;
        endcase
        return {fl[15], (fl == 16'h0), c, v, r};
    endfunction

    task automatic step(input logic [15:0] i, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        instr = i;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        instr = 16'hC100;
        a     = 16'($urandom);
        b     = 16'($urandom);
        #2;
        vectors++;
        if (result !== 16'h0000 || code !== 4'b0000) begin
            $display("FAIL reset_async: result=%h code=%b, want 0000 0000", result, code);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add;
        step(16'hC100, 16'h0001, 16'h0002);
        vectors++;
        if (result !== 16'h0003 || code !== 4'b0000) begin
            $display("FAIL add_basic: result=%h code=%b, want 0003 0000", result, code);
            miscompares++;
        end
        step(16'hC100, 16'h0001, 16'h0001);
        vectors++;
        if (result !== 16'h0002 || code !== 4'b0000) begin
            $display("FAIL add_second: result=%h code=%b, want 0002 0000", result, code);
            miscompares++;
        end
        step(16'hC100, 16'h0001, 16'h7FFF);
        vectors++;
        if (result !== 16'h8000 || code !== 4'b1001) begin
            $display("FAIL add_overflow: result=%h code=%b, want 8000 1001", result, code);
            miscompares++;
        end
        step(16'hC100, 16'h0001, 16'hFFFF);
        vectors++;
        if (result !== 16'h0000 || code !== 4'b0110) begin
            $display("FAIL add_carry: result=%h code=%b, want 0000 0110", result, code);
            miscompares++;
        end
    endtask

    task automatic test_sub_cmp;
        step(16'hC110, 16'h0005, 16'h0005);
        vectors++;
        if (result !== 16'h0000 || code !== 4'b0100) begin
            $display("FAIL sub_zero: result=%h code=%b, want 0000 0100", result, code);
            miscompares++;
        end
        step(16'hC150, 16'h0002, 16'h0001);
        vectors++;
        if (result !== 16'h0001 || code !== 4'b1010) begin
            $display("FAIL cmp_borrow: result=%h code=%b, want 0001 1010", result, code);
            miscompares++;
        end
        step(16'hC110, 16'h0001, 16'h8000);
        vectors++;
        if (result !== 16'h7FFF || code !== 4'b0001) begin
            $display("FAIL sub_overflow: result=%h code=%b, want 7fff 0001", result, code);
            miscompares++;
        end
    endtask

    task automatic test_shifts;
        step(16'hC181, 16'h1234, 16'h8001);
        vectors++;
        if (result !== 16'h0002 || code !== 4'b0010) begin
            $display("FAIL sll_1: result=%h code=%b, want 0002 0010", result, code);
            miscompares++;
        end
        step(16'hC1B4, 16'h1234, 16'h8001);
        vectors++;
        if (result !== 16'hF800 || code !== 4'b1000) begin
            $display("FAIL sra_4: result=%h code=%b, want f800 1000", result, code);
            miscompares++;
        end
        step(16'hC191, 16'h1234, 16'h8001);
        vectors++;
        if (result !== 16'h0003 || code !== 4'b0010) begin
            $display("FAIL slr_1: result=%h code=%b, want 0003 0010", result, code);
            miscompares++;
        end
        step(16'hC1AF, 16'h0000, 16'h8000);
        vectors++;
        if (result !== 16'h0001 || code !== 4'b0000) begin
            $display("FAIL srl_15: result=%h code=%b, want 0001 0000", result, code);
            miscompares++;
        end
        step(16'hC180, 16'h0000, 16'h8001);
        vectors++;
        if (result !== 16'h8001 || code !== 4'b1000) begin
            $display("FAIL sll_0: result=%h code=%b, want 8001 1000", result, code);
            miscompares++;
        end
    endtask

    task automatic test_illegal;
        step(16'hC0F0, 16'h1234, 16'h5678);
        vectors++;
        if (result !== 16'h0000 || code !== 4'b0000) begin
            $display("FAIL hlt: result=%h code=%b, want 0000 0000", result, code);
            miscompares++;
        end
        step(16'h4100, 16'h0001, 16'h0002);
        vectors++;
        if (result !== 16'h0000 || code !== 4'b0000) begin
            $display("FAIL non_alu: result=%h code=%b, want 0000 0000", result, code);
            miscompares++;
        end
    endtask

    task automatic test_random;
        logic [15:0] ri;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [19:0] exp;
        for (int n = 0; n < 400; n++) begin
            ri = 16'($urandom);
            if ($urandom_range(7, 0) != 0) ri[15:14] = 2'b11;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(5, 0) == 0) ra = rb;
            exp = ref_alu(ri, ra, rb);
            step(ri, ra, rb);
            vectors++;
            if (result !== exp[15:0] || code !== exp[19:16]) begin
                $display("FAIL random: instr=%h a=%h b=%h result=%h code=%b, want %h %b",
                         ri, ra, rb, result, code, exp[15:0], exp[19:16]);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [19:0] exp;
        step(16'hC130, 16'h00F0, 16'h0F0F);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (result !== 16'h0000 || code !== 4'b0000) begin
            $display("FAIL reset_mid: result=%h code=%b, want 0000 0000", result, code);
            miscompares++;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (result !== 16'h0000 || code !== 4'b0000) begin
            $display("FAIL reset_hold: result=%h code=%b, want 0000 0000", result, code);
            miscompares++;
        end
        @(negedge clk);
        rst   = 1'b0;
        instr = 16'hC110;
        a     = 16'h0003;
        b     = 16'h0001;
        exp   = ref_alu(instr, a, b);
        @(posedge clk);
        #1;
        vectors++;
        if (result !== exp[15:0] || code !== exp[19:16]) begin
            $display("FAIL reset_release: result=%h code=%b, want %h %b",
                     result, code, exp[15:0], exp[19:16]);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        instr       = 16'h0000;
        a           = 16'h0000;
        b           = 16'h0000;
        test_reset;
        test_add;
        test_sub_cmp;
        test_shifts;
        test_illegal;
        test_random;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
